// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: applies EX redirects and trap vectors, drains stale
// instruction-memory responses, and traps on misaligned branch targets.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FLUSH_SLOTS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vector,
    output logic [31:0] pc,
    output logic        flush,
    output logic        fetch_valid,
    output logic        misaligned_exc,
    output logic [31:0] misaligned_addr
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DRAIN     = 2'd1,
        TRAP_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] SLOTS = 4'(FLUSH_SLOTS);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [31:0] pc_next;
    logic        exc_next;
    logic [31:0] addr_next;
    logic        take;
    logic        good_take;
    logic        bad_take;

    // Branch inputs are dead while waiting for the trap redirect.
    assign take      = branch_valid & branch_taken & (state != TRAP_WAIT);
    assign good_take = take & (branch_target[1:0] == 2'b00);
    assign bad_take  = take & (branch_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            cnt             <= 4'd0;
            pc              <= RESET_PC;
            fetch_valid     <= 1'b0;
            misaligned_exc  <= 1'b0;
            misaligned_addr <= 32'd0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            pc              <= pc_next;
            fetch_valid     <= (state_next == RUN);
            misaligned_exc  <= exc_next;
            misaligned_addr <= addr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pc_next    = pc;
        exc_next   = 1'b0;
        addr_next  = misaligned_addr;
        if (trap_req) begin
            pc_next    = trap_vector;
            cnt_next   = SLOTS;
            state_next = DRAIN;
        end else if (good_take) begin
            pc_next    = branch_target;
            cnt_next   = SLOTS;
            state_next = DRAIN;
        end else if (bad_take) begin
            exc_next   = 1'b1;
            addr_next  = branch_target;
            cnt_next   = 4'd0;
            state_next = TRAP_WAIT;
        end else if (state != TRAP_WAIT && !stall) begin
            pc_next = pc + 32'd4;
            if (state == DRAIN) begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = RUN;
                end
            end
        end
    end

    always_comb begin
        flush = trap_req | take;
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed vector table, async reset check,
// then randomized traffic against a behavioural model.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_valid;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap_req;
    logic [31:0] trap_vector;
    logic [31:0] pc;
    logic        flush;
    logic        fetch_valid;
    logic        misaligned_exc;
    logic [31:0] misaligned_addr;

    int checks = 0;
    int errors = 0;

    localparam int N = 2;

    pc_redirect_unit #(
        .RESET_PC(32'h0000_0000),
        .FLUSH_SLOTS(N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branch_valid(branch_valid),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .trap_req(trap_req),
        .trap_vector(trap_vector),
        .pc(pc),
        .flush(flush),
        .fetch_valid(fetch_valid),
        .misaligned_exc(misaligned_exc),
        .misaligned_addr(misaligned_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        bv;
        logic        bt;
        logic [31:0] tgt;
        logic        tr;
        logic [31:0] tv;
        logic [31:0] e_pc;
        logic        e_fl;
        logic        e_fv;
        logic        e_exc;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[30];

    // Behavioural model: stale responses left to discard, plus trap-wait flag
    logic [31:0] m_pc;
    int          m_left;
    bit          m_wait;
    bit          m_fv;
    bit          m_exc;
    logic [31:0] m_addr;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic bv,
                                input logic bt, input logic [31:0] tgt,
                                input logic tr, input logic [31:0] tv,
                                input logic [31:0] p, input logic fl,
                                input logic fv, input logic ex,
                                input logic [31:0] ad);
        vec_t v;
        v.st = st; v.bv = bv; v.bt = bt; v.tgt = tgt;
        v.tr = tr; v.tv = tv; v.e_pc = p; v.e_fl = fl;
        v.e_fv = fv; v.e_exc = ex; v.e_addr = ad;
        return v;
    endfunction

    task automatic drive(input logic st, input logic bv, input logic bt,
                         input logic [31:0] tgt, input logic tr,
                         input logic [31:0] tv);
        stall = st; branch_valid = bv; branch_taken = bt;
        branch_target = tgt; trap_req = tr; trap_vector = tv;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_left = 0; m_wait = 0;
        m_fv = 0; m_exc = 0; m_addr = 32'h0;
    endtask

    function automatic bit model_flush();
        return trap_req || (branch_valid && branch_taken && !m_wait);
    endfunction

    task automatic model_edge();
        bit tk;
        tk = branch_valid && branch_taken && !m_wait;
        m_exc = 0;
        if (trap_req) begin
            m_pc = trap_vector; m_left = N; m_wait = 0;
        end else if (tk && branch_target % 4 == 0) begin
            m_pc = branch_target; m_left = N;
        end else if (tk) begin
            m_wait = 1; m_exc = 1; m_addr = branch_target; m_left = 0;
        end else if (!m_wait && !stall) begin
            m_pc = m_pc + 32'd4;
            if (m_left > 0) m_left--;
        end
        m_fv = !m_wait && m_left == 0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tbl[0]  = mk(0,0,0,32'h0,0,32'h0, 32'h4,0,1,0,32'h0);
        tbl[1]  = mk(0,0,0,32'h0,0,32'h0, 32'h8,0,1,0,32'h0);
        tbl[2]  = mk(0,1,1,32'h100,0,32'h0, 32'h100,1,0,0,32'h0);
        tbl[3]  = mk(0,0,0,32'h0,0,32'h0, 32'h104,0,0,0,32'h0);
        tbl[4]  = mk(0,0,0,32'h0,0,32'h0, 32'h108,0,1,0,32'h0);
        tbl[5]  = mk(0,0,0,32'h0,0,32'h0, 32'h10C,0,1,0,32'h0);
        tbl[6]  = mk(0,1,1,32'h100,0,32'h0, 32'h100,1,0,0,32'h0);
        tbl[7]  = mk(1,0,0,32'h0,0,32'h0, 32'h100,0,0,0,32'h0);
        tbl[8]  = mk(0,0,0,32'h0,0,32'h0, 32'h104,0,0,0,32'h0);
        tbl[9]  = mk(0,0,0,32'h0,0,32'h0, 32'h108,0,1,0,32'h0);
        tbl[10] = mk(0,1,1,32'h102,0,32'h0, 32'h108,1,0,1,32'h102);
        tbl[11] = mk(0,1,1,32'h300,0,32'h0, 32'h108,0,0,0,32'h102);
        tbl[12] = mk(1,0,0,32'h0,0,32'h0, 32'h108,0,0,0,32'h102);
        tbl[13] = mk(0,0,0,32'h0,1,32'h200, 32'h200,1,0,0,32'h102);
        tbl[14] = mk(0,0,0,32'h0,0,32'h0, 32'h204,0,0,0,32'h102);
        tbl[15] = mk(0,0,0,32'h0,0,32'h0, 32'h208,0,1,0,32'h102);
        tbl[16] = mk(0,1,1,32'h100,1,32'h200, 32'h200,1,0,0,32'h102);
        tbl[17] = mk(0,0,0,32'h0,0,32'h0, 32'h204,0,0,0,32'h102);
        tbl[18] = mk(0,0,0,32'h0,0,32'h0, 32'h208,0,1,0,32'h102);
        tbl[19] = mk(0,1,1,32'h102,1,32'h300, 32'h300,1,0,0,32'h102);
        tbl[20] = mk(0,0,0,32'h0,0,32'h0, 32'h304,0,0,0,32'h102);
        tbl[21] = mk(0,0,0,32'h0,0,32'h0, 32'h308,0,1,0,32'h102);
        tbl[22] = mk(0,0,0,32'h0,1,32'hFFFF_FFF8,
                     32'hFFFF_FFF8,1,0,0,32'h102);
        tbl[23] = mk(0,0,0,32'h0,0,32'h0, 32'hFFFF_FFFC,0,0,0,32'h102);
        tbl[24] = mk(0,0,0,32'h0,0,32'h0, 32'h0,0,1,0,32'h102);
        tbl[25] = mk(0,1,1,32'h40,0,32'h0, 32'h40,1,0,0,32'h102);
        tbl[26] = mk(0,1,1,32'h41,0,32'h0, 32'h40,1,0,1,32'h41);
        tbl[27] = mk(1,0,0,32'h0,1,32'h80, 32'h80,1,0,0,32'h41);
        tbl[28] = mk(0,0,1,32'h500,0,32'h0, 32'h84,0,0,0,32'h41);
        tbl[29] = mk(0,0,0,32'h0,0,32'h0, 32'h88,0,1,0,32'h41);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_exc", {31'd0, misaligned_exc}, 32'd0);
        chk("rst_addr", misaligned_addr, 32'h0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].st, tbl[i].bv, tbl[i].bt, tbl[i].tgt,
                  tbl[i].tr, tbl[i].tv);
            #1;
            chk($sformatf("v%0d_flush", i), {31'd0, flush},
                {31'd0, tbl[i].e_fl});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d_fv", i), {31'd0, fetch_valid},
                {31'd0, tbl[i].e_fv});
            chk($sformatf("v%0d_exc", i), {31'd0, misaligned_exc},
                {31'd0, tbl[i].e_exc});
            chk($sformatf("v%0d_addr", i), misaligned_addr, tbl[i].e_addr);
        end

        // Asynchronous reset in the middle of a drain window
        drive(0, 1, 1, 32'h600, 0, 32'h0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        chk("pre_arst_pc", pc, 32'h600);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_fv", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 6, t,
                  $urandom_range(0, 19) == 0,
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            #1;
            chk("rnd_flush", {31'd0, flush}, {31'd0, model_flush()});
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd_pc", pc, m_pc);
            chk("rnd_fv", {31'd0, fetch_valid}, {31'd0, m_fv});
            chk("rnd_exc", {31'd0, misaligned_exc}, {31'd0, m_exc});
            chk("rnd_addr", misaligned_addr, m_addr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
